jtpopeye_dma: RTL and testbench

Object-RAM DMA controller for the Popeye main board. On each rising edge of its start input (VBLANK), it requests the Z80 bus and waits for the grant. It then streams the 1 kB object window of main RAM through the `AD_DMA`/`DD_DMA`/`dma_cs` port into the video object buffer, and finally hands the bus back. It sits between `jtpopeye_main` (bus request/grant, RAM read port) and the video object logic.

---
 rtl/jtpopeye_dma.sv | 275 +++++++++++++++++++++++++++
 tb/tb_jtpopeye_dma.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_dma.sv
// Object-RAM DMA controller for the Popeye main board.
//
// On each rising edge of start (VBLANK) the block requests the Z80 bus, waits for
// the grant, streams the 2^AW-byte object window of main RAM from the AD_DMA/DD_DMA
// port into the video object buffer, and then hands the bus back.
//
// Sequence: IDLE -> REQ -> XFER -> DRAIN -> REL -> IDLE. A grant timeout in REQ
// sets err and returns to IDLE without done. Every state change, and every output
// change, happens only on cycles with cen=1.
//
// Optional feature: define JTPOPEYE_DMA_SUM_EN to build the XOR accumulator that
// drives dma_sum. Without it dma_sum is tied to 8'h00 and nothing else changes.
//
// Parameters:
//   AW        DMA address width; one transfer moves 2^AW bytes
//   RD_LAT    cen periods from an AD_DMA change to valid DD_DMA (>= 1)
//   GRANT_TO  cen periods to wait for busak_n before giving up
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset; drops the bus request at once
//   cen       CPU clock enable
//   start     trigger level (VB), rising edge detected on cen
//   busrq_n   Z80 bus request (registered)
//   busak_n   Z80 bus acknowledge
//   dma_cs    main RAM serves the DMA port
//   AD_DMA    RAM read address
//   DD_DMA    RAM read data
//   obj_we    object buffer write strobe, one cen period wide
//   obj_addr  object buffer address
//   obj_data  object buffer data
//   busy      high in every state except IDLE
//   done      one cen period pulse on normal completion
//   err       grant timeout flag, cleared by the next accepted start
//   dma_sum   XOR of the bytes written by the last completed transfer

module jtpopeye_dma #(
  parameter int unsigned AW       = 10,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned GRANT_TO = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          start,
  output logic          busrq_n,
  input  logic          busak_n,
  output logic          dma_cs,
  output logic [AW-1:0] AD_DMA,
  input  logic [7:0]    DD_DMA,
  output logic          obj_we,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    dma_sum
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StXfer,
    StDrain,
    StRel
  } state_e;

  state_e        state_q, state_d;

  logic          start_q;
  logic          start_edge;
  logic          accept;

  logic [15:0]   to_q, to_d;
  logic [7:0]    drain_q, drain_d;
  logic [AW-1:0] ad_q, ad_d;

  logic          busrq_n_q, busrq_n_d;
  logic          dma_cs_q, dma_cs_d;
  logic          busy_q;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          issue;

  // Read tag delay line: stage 0 is loaded on the issuing cen, the last stage
  // matches the cen on which DD_DMA holds that address's byte.
  logic [RD_LAT-1:0] tag_v_q;
  logic [AW-1:0]     tag_a_q [RD_LAT];
  logic              tag_out;

  logic          obj_we_q;
  logic [AW-1:0] obj_addr_q;
  logic [7:0]    obj_data_q;

  assign start_edge = start & ~start_q;
  // Edges while busy are dropped, never queued.
  assign accept     = (state_q == StIdle) && start_edge;
  assign tag_out    = tag_v_q[RD_LAT-1];

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    drain_d   = drain_q;
    ad_d      = ad_q;
    busrq_n_d = busrq_n_q;
    dma_cs_d  = dma_cs_q;
    done_d    = 1'b0;
    err_d     = err_q;
    issue     = 1'b0;

    unique case (state_q)
      StIdle: begin
        busrq_n_d = 1'b1;
        dma_cs_d  = 1'b0;
        if (accept) begin
          err_d     = 1'b0;
          to_d      = 16'(GRANT_TO);
          busrq_n_d = 1'b0;
          state_d   = StReq;
        end
      end

      StReq: begin
        busrq_n_d = 1'b0;
        if (!busak_n) begin
          ad_d     = '0;
          dma_cs_d = 1'b1;
          state_d  = StXfer;
        end else if (to_q == '0) begin
          // Counter already exhausted: GRANT_TO+1 ungranted cen periods in total.
          err_d     = 1'b1;
          busrq_n_d = 1'b1;
          state_d   = StIdle;
        end else begin
          to_d = to_q - 16'd1;
        end
      end

      StXfer: begin
        issue = 1'b1;
        if (&ad_q) begin
          // Last address stays on the bus; no wrap back to zero.
          drain_d = 8'(RD_LAT - 1);
          state_d = StDrain;
        end else begin
          ad_d = ad_q + 1'b1;
        end
      end

      StDrain: begin
        if (drain_q == '0) begin
          dma_cs_d  = 1'b0;
          busrq_n_d = 1'b1;
          state_d   = StRel;
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end

      StRel: begin
        dma_cs_d  = 1'b0;
        busrq_n_d = 1'b1;
        if (busak_n) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        busrq_n_d = 1'b1;
        dma_cs_d  = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Control registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      to_q      <= '0;
      drain_q   <= '0;
      ad_q      <= '0;
      busrq_n_q <= 1'b1;
      dma_cs_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (cen) begin
      state_q   <= state_d;
      start_q   <= start;
      to_q      <= to_d;
      drain_q   <= drain_d;
      ad_q      <= ad_d;
      busrq_n_q <= busrq_n_d;
      dma_cs_q  <= dma_cs_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  //--------------------------------------------------------------------------
  // Read tag pipeline and object buffer write port
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_a_q[i] <= '0;
      end
      obj_we_q   <= 1'b0;
      obj_addr_q <= '0;
      obj_data_q <= '0;
    end else if (cen) begin
      tag_v_q[0] <= issue;
      tag_a_q[0] <= ad_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_a_q[i] <= tag_a_q[i-1];
      end
      obj_we_q <= tag_out;
      if (tag_out) begin
        obj_addr_q <= tag_a_q[RD_LAT-1];
        obj_data_q <= DD_DMA;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Optional transfer checksum
  //--------------------------------------------------------------------------
`ifdef JTPOPEYE_DMA_SUM_EN
  logic [7:0] sum_q;
  logic [7:0] dma_sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      dma_sum_q <= '0;
    end else if (cen) begin
      if (accept) begin
        sum_q <= '0;
      end else if (tag_out) begin
        sum_q <= sum_q ^ DD_DMA;
      end
      // The last byte is folded in on REL entry, always before done.
      if (done_d) begin
        dma_sum_q <= sum_q;
      end
    end
  end

  assign dma_sum = dma_sum_q;
`else
  assign dma_sum = 8'h00;
`endif

  assign busrq_n  = busrq_n_q;
  assign dma_cs   = dma_cs_q;
  assign AD_DMA   = ad_q;
  assign obj_we   = obj_we_q;
  assign obj_addr = obj_addr_q;
  assign obj_data = obj_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Scoreboard bench for jtpopeye_dma. Stimulus pushes the expected object buffer
// writes into a queue; a monitor pops and compares on every obj_we. A pipelined RAM
// model serves DD_DMA and a bus model answers busrq_n with configurable delays.
module tb_jtpopeye_dma;

  localparam int AW     = 10;
  localparam int RD_LAT = 2;
  localparam int NBYTES = 1 << AW;

`ifdef JTPOPEYE_DMA_SUM_EN
  localparam logic [7:0] SUM_EXP = 8'h5A;
`else
  localparam logic [7:0] SUM_EXP = 8'h00;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen = 1'b0;
  logic          start;
  logic          busrq_n;
  logic          busak_n;
  logic          dma_cs;
  logic [AW-1:0] AD_DMA;
  logic [7:0]    DD_DMA;
  logic          obj_we;
  logic [AW-1:0] obj_addr;
  logic [7:0]    obj_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    dma_sum;

  jtpopeye_dma #(
    .AW       (AW),
    .RD_LAT   (RD_LAT),
    .GRANT_TO (255)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .start    (start),
    .busrq_n  (busrq_n),
    .busak_n  (busak_n),
    .dma_cs   (dma_cs),
    .AD_DMA   (AD_DMA),
    .DD_DMA   (DD_DMA),
    .obj_we   (obj_we),
    .obj_addr (obj_addr),
    .obj_data (obj_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .dma_sum  (dma_sum)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cen_cnt  = 0;
  int  n_wr     = 0;
  int  n_done   = 0;
  int  t_start, t_done, t_err, t_rqf;
  int  w0, d0;
  bit  cen_edge = 1'b0;
  bit  never    = 1'b0;
  bit  chk_rel  = 1'b0;
  int  glat     = 1;
  int  rlat     = 1;
  logic [7:0] ram [NBYTES];
  wr_t exp_q[$];

  always #5 clk = ~clk;

  // cen is high on every other clock; cen_edge remembers whether the last posedge
  // was an enabled one.
  initial begin
    forever begin
      @(posedge clk);
      cen_edge = cen;
      #1 cen = ~cen;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the negedge following n enabled clock edges.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (!cen_edge) @(negedge clk);
    end
    #1;
  endtask

  // RAM read port: RD_LAT cen periods from an address change to valid data.
  initial begin
    logic [7:0]    pipe [RD_LAT];
    logic [AW-1:0] a;
    for (int i = 0; i < RD_LAT; i++) pipe[i] = 8'h00;
    DD_DMA = 8'h00;
    forever begin
      @(posedge clk);
      if (cen) begin
        a = AD_DMA;
        #1;
        for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = ram[a];
        DD_DMA  = pipe[RD_LAT-1];
      end
    end
  end

  // Z80 bus model: acknowledge glat cen after the request falls, release rlat cen
  // after it rises; never=1 withholds the grant.
  initial begin
    logic [31:0] hist;
    hist    = '1;
    busak_n = 1'b1;
    forever begin
      step(1);
      hist = {hist[30:0], busrq_n};
      if (never) busak_n = 1'b1;
      else if (busak_n && !hist[glat]) busak_n = 1'b0;
      else if (!busak_n && hist[rlat]) busak_n = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every write and timestamps control events.
  initial begin
    wr_t  e;
    logic busrq_prev = 1'b1;
    logic err_prev   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && cen_edge) begin
        cen_cnt++;
        if (obj_we) begin
          n_wr++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                     obj_addr, obj_data);
          end else begin
            e = exp_q.pop_front();
            check("obj_write", {14'd0, obj_addr, obj_data}, {14'd0, e.addr, e.data});
          end
        end
        if (done) begin
          n_done++;
          t_done = cen_cnt;
        end
        if (err && !err_prev) t_err = cen_cnt;
        if (!busrq_n && busrq_prev) t_rqf = cen_cnt;
        if (chk_rel && busrq_n && busy) check("dma_cs_in_rel", dma_cs, 1'b0);
        busrq_prev = busrq_n;
        err_prev   = err;
      end
    end
  end

  task automatic run_start(input bit with_data);
    wr_t e;
    if (with_data) begin
      for (int i = 0; i < NBYTES; i++) begin
        e.addr = AW'(i);
        e.data = ram[i];
        exp_q.push_back(e);
      end
    end
    w0      = n_wr;
    d0      = n_done;
    start   = 1'b1;
    t_start = cen_cnt;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (n_done == d0 && k < 3000) begin
      step(1);
      k++;
    end
    check(name, 32'(n_done != d0), 32'd1);
  endtask

  task automatic wait_addr(input logic [AW-1:0] a, input string name);
    int k = 0;
    while (AD_DMA !== a && k < 3000) begin
      step(1);
      k++;
    end
    check(name, 32'(AD_DMA), 32'(a));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busrq_n"}, busrq_n, 1'b1);
    check({tag, "_dma_cs"}, dma_cs, 1'b0);
    check({tag, "_ad"}, 32'(AD_DMA), 32'd0);
    check({tag, "_obj_we"}, obj_we, 1'b0);
    check({tag, "_obj_addr"}, 32'(obj_addr), 32'd0);
    check({tag, "_obj_data"}, 32'(obj_data), 32'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_dma_sum"}, 32'(dma_sum), 32'd0);
  endtask

  task automatic check_transfer(input string tag);
    step(3);
    check({tag, "_writes"}, 32'(n_wr - w0), 32'(NBYTES));
    check({tag, "_done_cnt"}, 32'(n_done - d0), 32'd1);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_busrq_n"}, busrq_n, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_dma_sum"}, 32'(dma_sum), 32'(SUM_EXP));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    // Pattern whose XOR over the whole window is 0x5A.
    for (int i = 0; i < NBYTES; i++) begin
      a      = AW'(i);
      ram[i] = a[7:0] ^ 8'h3C ^ {a[9:8], 6'b0};
    end
    ram[NBYTES-1] = 8'h59;

    rst_n = 1'b0;
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step(4);

    // Normal transfer, grant 3 cen after the request.
    glat = 3;
    run_start(1'b1);
    step(2);
    check("t1_rq_latency", 32'(t_rqf - t_start), 32'd1);
    wait_done("t1_done_seen");
    check_transfer("t1");
    start = 1'b0;
    step(4);

    // Grant never comes: timeout after GRANT_TO+1 cen, no writes, no done.
    never = 1'b1;
    run_start(1'b0);
    begin
      int k = 0;
      while (!err && k < 600) begin
        step(1);
        k++;
      end
    end
    check("t2_err_set", err, 1'b1);
    check("t2_err_time", 32'(t_err - t_rqf), 32'd256);
    check("t2_busrq_n", busrq_n, 1'b1);
    check("t2_busy", busy, 1'b0);
    step(4);
    check("t2_writes", 32'(n_wr - w0), 32'd0);
    check("t2_done_cnt", 32'(n_done - d0), 32'd0);
    check("t2_err_held", err, 1'b1);
    start = 1'b0;
    never = 1'b0;
    glat  = 1;
    rlat  = 1;
    step(4);

    // Immediate grant and release: start edge to done is 2^AW + RD_LAT + 4 cen.
    run_start(1'b1);
    step(2);
    check("t3_err_clr", err, 1'b0);
    wait_done("t3_done_seen");
    check("t3_latency", 32'(t_done - t_start - 1), 32'd1030);
    check_transfer("t3");
    start = 1'b0;
    step(4);

    // Second start edge mid-transfer is ignored.
    glat = 2;
    run_start(1'b1);
    wait_addr(10'h100, "t4_reach_100");
    start = 1'b0;
    step(2);
    start = 1'b1;
    step(2);
    start = 1'b0;
    wait_done("t4_done_seen");
    step(20);
    check("t4_no_requeue", 32'(n_done - d0), 32'd1);
    check_transfer("t4");
    step(4);

    // Reset in the middle of the transfer, then a clean transfer.
    glat = 1;
    run_start(1'b1);
    wait_addr(10'h155, "t5_reach_155");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_midrst");
    exp_q.delete();
    start = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(20);
    run_start(1'b1);
    wait_done("t5_done_seen");
    check_transfer("t5");
    start = 1'b0;
    step(4);

    // Late release: done waits 10 more cen, dma_cs low throughout REL.
    rlat    = 11;
    chk_rel = 1'b1;
    run_start(1'b1);
    wait_done("t6_done_seen");
    check("t6_latency", 32'(t_done - t_start - 1), 32'd1040);
    chk_rel = 1'b0;
    check_transfer("t6");
    start = 1'b0;
    rlat  = 1;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
